// File: rtl/store_buffer_if.sv
// Request/response word bus shared by the cpu and memory sides of the store buffer.
// master issues read/write requests; slave answers with a one-cycle resp pulse.
interface store_buffer_if;
  logic        read;
  logic        write;
  logic [3:0]  byte_enable;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output read, write, byte_enable, address, wdata,
    input  resp, rdata
  );

  modport slave (
    input  read, write, byte_enable, address, wdata,
    output resp, rdata
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write buffer: stores are acked once queued and drained to memory in
// program order; loads wait for an empty buffer so they see every earlier store.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  cpu,
  store_buffer_if.master mem
);

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [31:0]      r_fifo_addr [DEPTH];
  logic [31:0]      r_fifo_data [DEPTH];
  logic [3:0]       r_fifo_be   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_st_pend;

  logic             r_cpu_resp;
  logic [31:0]      r_cpu_rdata;
  logic             r_mem_read;
  logic             r_mem_write;
  logic [3:0]       r_mem_be;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_pop;
  logic             w_load_done;
  logic             w_mem_read_nxt;
  logic             w_mem_write_nxt;
  logic [3:0]       w_mem_be_nxt;
  logic [31:0]      w_mem_addr_nxt;
  logic [31:0]      w_mem_wdata_nxt;

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // r_st_pend marks a store that was acked while the cpu still holds the request,
  // so a request held past the resp cycle is not queued a second time.
  assign w_enq = cpu.write & ~cpu.read & ~r_cpu_resp & ~w_full & ~r_st_pend;

  assign cpu.resp        = r_cpu_resp;
  assign cpu.rdata       = r_cpu_rdata;
  assign mem.read        = r_mem_read;
  assign mem.write       = r_mem_write;
  assign mem.byte_enable = r_mem_be;
  assign mem.address     = r_mem_addr;
  assign mem.wdata       = r_mem_wdata;

  // Entry storage; contents are don't-care until written, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_addr[r_wr_ptr] <= cpu.address;
      r_fifo_data[r_wr_ptr] <= cpu.wdata;
      r_fifo_be[r_wr_ptr]   <= cpu.byte_enable;
    end
  end

  // Pointers, occupancy and the acked-pending flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_st_pend <= 1'b0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_st_pend <= w_enq | (r_st_pend & cpu.write & ~cpu.read);
    end
  end

  // Memory-side state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and next values of the registered memory-side outputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_pop           = 1'b0;
    w_load_done     = 1'b0;
    w_mem_read_nxt  = r_mem_read;
    w_mem_write_nxt = r_mem_write;
    w_mem_be_nxt    = r_mem_be;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_mem_addr_nxt  = r_fifo_addr[r_rd_ptr];
          w_mem_wdata_nxt = r_fifo_data[r_rd_ptr];
          w_mem_be_nxt    = r_fifo_be[r_rd_ptr];
          w_mem_write_nxt = 1'b1;
          w_state_nxt     = DRAIN;
        end else if (cpu.read && !r_cpu_resp) begin
          w_mem_addr_nxt  = cpu.address;
          w_mem_be_nxt    = cpu.byte_enable;
          w_mem_read_nxt  = 1'b1;
          w_state_nxt     = READ;
        end
      end
      DRAIN: begin
        if (mem.resp) begin
          w_pop           = 1'b1;
          w_mem_write_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      READ: begin
        if (mem.resp) begin
          w_load_done    = 1'b1;
          w_mem_read_nxt = 1'b0;
          w_state_nxt    = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs to both sides.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_resp  <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_cpu_resp  <= w_enq | w_load_done;
      if (w_load_done) r_cpu_rdata <= mem.rdata;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: scoreboard of expected memory writes,
// a shadow memory for load data, and a latency-configurable memory responder.
module tb_store_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if cpu_if ();
  store_buffer_if mem_if ();

  store_buffer #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (cpu_if),
    .mem (mem_if)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  wr_t         sb_wr[$];
  logic [31:0] mem_model [logic [29:0]];
  logic [31:0] shadow    [logic [29:0]];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned wr_done = 0;
  int unsigned last_hold = 0;
  int unsigned rd_resp_cyc = 0;
  int unsigned fixed_lat = 0;
  int unsigned st_total = 0;
  bit          hold_mem = 1'b0;
  bit          rand_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return mem_model.exists(a[31:2]) ? mem_model[a[31:2]] : default_word(a);
  endfunction

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a[31:2]) ? shadow[a[31:2]] : default_word(a);
  endfunction

  // Memory responder: answers each request after a fixed or random latency.
  initial begin
    bit          active;
    int unsigned waitc;
    int unsigned hold_cyc;
    wr_t         e;
    active   = 1'b0;
    waitc    = 0;
    hold_cyc = 0;
    mem_if.resp  = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      mem_if.resp = 1'b0;
      if (!rst) begin
        active = 1'b0;
      end else if ((mem_if.write || mem_if.read) && !hold_mem) begin
        if (!active) begin
          active   = 1'b1;
          hold_cyc = 0;
          waitc    = rand_lat ? $urandom_range(4, 0) : fixed_lat;
          check("mem_rw_excl", {31'b0, mem_if.write & mem_if.read}, 32'd0);
          if (mem_if.read) check("ld_order_empty", sb_wr.size(), 32'd0);
        end
        hold_cyc++;
        if (waitc == 0) begin
          mem_if.resp = 1'b1;
          active      = 1'b0;
          last_hold   = hold_cyc;
          if (mem_if.write) begin
            check("wr_expected", {31'b0, sb_wr.size() != 0}, 32'd1);
            if (sb_wr.size() != 0) begin
              e = sb_wr.pop_front();
              check("wr_addr", mem_if.address, e.addr);
              check("wr_data", mem_if.wdata, e.data);
              check("wr_be", {28'b0, mem_if.byte_enable}, {28'b0, e.be});
            end
            mem_model[mem_if.address[31:2]] = merge(model_rd(mem_if.address), mem_if.wdata,
                                                    mem_if.byte_enable);
            wr_done++;
          end else begin
            mem_if.rdata = model_rd(mem_if.address);
            rd_resp_cyc  = cyc;
          end
        end else begin
          waitc--;
        end
      end
    end
  end

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_if.write       = 1'b1;
    cpu_if.read        = 1'b0;
    cpu_if.address     = a;
    cpu_if.wdata       = d;
    cpu_if.byte_enable = be;
    sb_wr.push_back('{addr: a, data: d, be: be});
    shadow[a[31:2]] = merge(shadow_rd(a), d, be);
    st_total++;
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input int unsigned extra_hold, output int unsigned lat);
    @(negedge clk);
    drive_store(a, d, be);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!cpu_if.resp && lat < 60);
    check("st_ack", {31'b0, cpu_if.resp}, 32'd1);
    repeat (extra_hold) @(negedge clk);
    cpu_if.write = 1'b0;
  endtask

  task automatic cpu_load(input logic [31:0] a, input bit also_write, output logic [31:0] d);
    logic [31:0] exp;
    int unsigned n;
    @(negedge clk);
    cpu_if.read        = 1'b1;
    cpu_if.write       = also_write;
    cpu_if.address     = a;
    cpu_if.wdata       = 32'h0BAD_0BAD;
    cpu_if.byte_enable = 4'hF;
    exp = shadow_rd(a);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_if.resp && n < 80);
    check("ld_ack", {31'b0, cpu_if.resp}, 32'd1);
    check("ld_data", cpu_if.rdata, exp);
    check("ld_resp_lat", cyc - rd_resp_cyc, 32'd1);
    d = cpu_if.rdata;
    cpu_if.read  = 1'b0;
    cpu_if.write = 1'b0;
    @(negedge clk);
    check("ld_rdata_hold", cpu_if.rdata, exp);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned n;
    n = 0;
    while ((sb_wr.size() != 0 || mem_if.write || mem_if.read) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, (sb_wr.size() != 0) || mem_if.write}, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cpu_resp"}, {31'b0, cpu_if.resp}, 32'd0);
    check({tag, "_cpu_rdata"}, cpu_if.rdata, 32'd0);
    check({tag, "_mem_read"}, {31'b0, mem_if.read}, 32'd0);
    check({tag, "_mem_write"}, {31'b0, mem_if.write}, 32'd0);
    check({tag, "_mem_addr"}, mem_if.address, 32'd0);
    check({tag, "_mem_wdata"}, mem_if.wdata, 32'd0);
    check({tag, "_mem_be"}, {28'b0, mem_if.byte_enable}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned lat;
    int unsigned w0;
    int unsigned n;
    bit          seen;
    logic [31:0] d;
    logic [31:0] a;

    cpu_if.read        = 1'b0;
    cpu_if.write       = 1'b0;
    cpu_if.byte_enable = '0;
    cpu_if.address     = '0;
    cpu_if.wdata       = '0;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rst0");
    check("rst0_count", {29'b0, dut.r_count}, 32'd0);
    rst = 1'b1;

    // Single store with a 3-cycle memory latency.
    fixed_lat = 3;
    cpu_store(32'h0000_0100, 32'hDEADBEEF, 4'hF, 0, lat);
    check("sw_ack_lat", lat, 32'd1);
    wait_drain("sw_drain");
    check("sw_mem_hold", last_hold, 32'd4);
    check("sw_count", {29'b0, dut.r_count}, 32'd0);

    // Full stall: memory withheld, fifth store must wait for the first pop.
    hold_mem  = 1'b1;
    fixed_lat = 1;
    w0 = wr_done;
    for (int i = 0; i < 4; i++) begin
      cpu_store(32'h10 + 32'(4 * i), 32'hF000_0000 + 32'(i), 4'hF, 0, lat);
      check("full_ack_lat", lat, 32'd1);
    end
    @(negedge clk);
    drive_store(32'h20, 32'hF000_0004, 4'hF);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_if.resp) seen = 1'b1;
    end
    check("full_stall_noack", {31'b0, seen}, 32'd0);
    check("full_stall_nopop", wr_done - w0, 32'd0);
    hold_mem = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_if.resp && n < 40);
    check("full_late_ack", {31'b0, cpu_if.resp}, 32'd1);
    check("full_ack_after_pop", wr_done - w0, 32'd1);
    cpu_if.write = 1'b0;
    wait_drain("full_drain");
    check("full_writes", wr_done - w0, 32'd5);

    // Load after stores: must wait for both drains, then see the byte store.
    fixed_lat = 2;
    cpu_store(32'h100, 32'h0000_00AA, 4'b0001, 0, lat);
    cpu_store(32'h104, 32'h1234_5678, 4'hF, 0, lat);
    cpu_load(32'h100, 1'b0, d);
    check("ld_byte0", {24'b0, d[7:0]}, 32'h0000_00AA);

    // Read and write together: read wins, no write is queued.
    w0 = wr_done;
    cpu_load(32'h104, 1'b1, d);
    repeat (4) @(negedge clk);
    check("rw_no_write", wr_done - w0, 32'd0);

    // Store request held through the ack cycle and one more.
    w0 = wr_done;
    cpu_store(32'h200, 32'hCAFE_F00D, 4'hF, 2, lat);
    wait_drain("hold_drain");
    repeat (4) @(negedge clk);
    check("hold_one_write", wr_done - w0, 32'd1);
    check("hold_count", {29'b0, dut.r_count}, 32'd0);

    // Wrap-around with random memory latency.
    rand_lat = 1'b1;
    w0 = wr_done;
    a  = 32'h300;
    for (int i = 0; i < 10; i++) begin
      a = 32'h300 + 32'(4 * $urandom_range(7, 0));
      cpu_store(a, $urandom, 4'($urandom_range(15, 1)), 0, lat);
    end
    cpu_load(a, 1'b0, d);
    wait_drain("wrap_drain");
    check("wrap_writes", wr_done - w0, 32'd10);
    check("wrap_wr_ptr", {30'b0, dut.r_wr_ptr}, st_total % 4);
    check("wrap_rd_ptr", {30'b0, dut.r_rd_ptr}, st_total % 4);
    rand_lat = 1'b0;

    // Reset in the middle of a drain with three entries queued.
    hold_mem  = 1'b1;
    fixed_lat = 1;
    for (int i = 0; i < 3; i++) cpu_store(32'h400 + 32'(4 * i), 32'h5500_0000 + 32'(i), 4'hF, 0, lat);
    repeat (2) @(negedge clk);
    check("rstm_in_drain", {31'b0, mem_if.write}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("rstm");
    check("rstm_count", {29'b0, dut.r_count}, 32'd0);
    sb_wr.delete();
    hold_mem = 1'b0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (mem_if.write || mem_if.read) seen = 1'b1;
    end
    check("rstm_no_write", {31'b0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the multicycle RV32I cpu memory port and the cache/memory port below it.
- Stores are acknowledged to the cpu as soon as they are queued, then drained to memory in program order.
- Loads wait until the buffer is empty, then issue to memory, so a load always observes every earlier store.
- Both sides use the same request/resp word protocol the cpu already speaks.

Parameters:
- DEPTH, 4, number of store entries; a power of two, 2 or more.
- PTR_W, $clog2(DEPTH), width of the read and write pointers.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_read  in  1  cpu load request; held until cpu_resp.
- cpu_write  in  1  cpu store request; held until cpu_resp.
- cpu_byte_enable  in  4  byte lanes of the cpu request.
- cpu_address  in  32  word-aligned cpu address.
- cpu_wdata  in  32  cpu store data.
- cpu_resp  out  1  single-cycle completion pulse to the cpu.
- cpu_rdata  out  32  load data; valid while cpu_resp=1.
- mem_read  out  1  load request to memory.
- mem_write  out  1  store request to memory.
- mem_byte_enable  out  4  byte lanes of the memory request.
- mem_address  out  32  memory address.
- mem_wdata  out  32  memory store data.
- mem_resp  in  1  memory completion pulse.
- mem_rdata  in  32  memory load data; valid with mem_resp.

Behaviour:
- Reset (rst=0, asynchronous):
  - count, pointers and state are cleared; state = IDLE.
  - cpu_resp, mem_read and mem_write are 0; cpu_rdata = 0; mem_address, mem_wdata and mem_byte_enable = 0.
  - Any in-flight memory transaction is abandoned and all entries are discarded.
- Storage: a circular FIFO of {address, wdata, byte_enable}.
  - wr_ptr and rd_ptr wrap modulo DEPTH.
  - count is PTR_W+1 bits wide. full = (count==DEPTH); empty = (count==0).
- Ack-cycle rule: any cpu request seen in a cycle where cpu_resp=1 is ignored. This prevents a double enqueue while the cpu is still holding the request.
- Store path, independent of the drain state machine:
  - Enqueue when cpu_write=1, cpu_read=0, cpu_resp=0, not full, and no store is already acked-pending.
  - cpu_resp pulses high exactly 1 cycle after the enqueue edge.
  - When full, the store stalls with no resp until a pop frees an entry.
  - An enqueue and a pop in the same cycle leave count unchanged.
- Memory-side state machine; all mem_* outputs are driven from flops or registered state only:
  - IDLE, count>0: load the head entry onto mem_address/mem_wdata/mem_byte_enable, assert mem_write, go to DRAIN. Draining is eager and takes priority over a pending load.
  - IDLE, empty, cpu_read=1, cpu_resp=0: drive mem_address/mem_byte_enable from the cpu, assert mem_read, go to READ.
  - DRAIN: hold mem_write and the head entry until mem_resp. On mem_resp, pop (rd_ptr+1, count-1), drop mem_write, go to IDLE. A back-to-back drain therefore leaves one idle cycle between writes.
  - READ: hold mem_read until mem_resp. On mem_resp, register mem_rdata into cpu_rdata, drop mem_read, go to RESP.
  - RESP: cpu_resp=1 for one cycle, then go to IDLE.
- Load latency: cpu_resp comes 1 cycle after the mem_resp of the load. Total latency is 2 cycles plus memory latency when the buffer is empty.
- A pending load blocks further stores; the cpu cannot issue both at once.
- cpu_read and cpu_write high together: the read takes priority and the write is ignored.
- cpu_rdata holds its last value outside cpu_resp.
- mem_resp seen in IDLE or RESP is ignored.
- mem_read and mem_write are never both high.

Test Plan:
- Reset mid-operation:
  - Assert rst=0 for 2 cycles during DRAIN with 3 entries queued -> all outputs 0, count=0.
  - After release, no mem_write appears without a new store.
- Single store:
  - Stimulus: sw 0x0000_0100, data 0xDEADBEEF, be 4'b1111.
  - Response: cpu_resp 1 cycle after the request. mem_write rises the cycle after enqueue with address 0x100, data 0xDEADBEEF, be 4'hF, and is held through a 3-cycle memory latency. Buffer ends empty.
- Full stall, DEPTH=4, memory resp withheld:
  - Stimulus: 5 stores to 0x10, 0x14, 0x18, 0x1C, 0x20.
  - Response: the first 4 are acked. The 5th gets no cpu_resp until the first mem_resp, then is acked. Memory sees the addresses in exactly that order.
- Load after stores:
  - Stimulus: sb 0x100 be 4'b0001 data 0x000000AA, then sw 0x104, then lw 0x100.
  - Response: mem_read stays low until both mem_write transactions get resp. The load then returns the memory model value with byte0=0xAA, and cpu_resp comes 1 cycle after the load's mem_resp.
- Ack-cycle hold:
  - Stimulus: the cpu holds cpu_write through the cpu_resp cycle and one extra cycle.
  - Response: exactly one entry is enqueued and exactly one mem_write transaction occurs.
- Wrap-around:
  - Stimulus: 10 stores with random memory latency (0-4 cycles) against a scoreboard.
  - Response: pointers wrap cleanly, with no lost, duplicated or reordered writes.
